// File: rtl/fifo_rd_packer_pkg.sv
// fifo_pkg: shared defaults and helpers for the FIFO read-side packer
//   DATA_WIDTH / PACK_RATIO : default word width and words per beat
//   CNT_W                   : width of a 0..PACK_RATIO lane counter
//   keep_mask(n)            : contiguous lane mask with the low n lanes set
package fifo_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int PACK_RATIO = 4;
    localparam int CNT_W = $clog2(PACK_RATIO + 1);

    function automatic logic [31:0] keep_mask(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction
endpackage

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: packed-beat valid/ready stream
//   data  : DATA_WIDTH*PACK_RATIO packed beat, lane 0 in the low bits
//   keep  : per-lane valid mask
//   valid : beat valid (master -> slave)
//   ready : beat accept (slave -> master)
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int PACK_RATIO = fifo_pkg::PACK_RATIO
);
    logic [DATA_WIDTH*PACK_RATIO-1:0] data;
    logic [PACK_RATIO-1:0]            keep;
    logic                             valid;
    logic                             ready;

    modport master(output data, keep, valid, input ready);
    modport slave(input data, keep, valid, output ready);
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a show-ahead FIFO and packs PACK_RATIO words per beat
//   rd_clk     : read-domain clock
//   rst        : asynchronous active-high reset
//   fifo_dout  : FIFO head word, valid while fifo_empty=0
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : pop strobe
//   flush      : one-cycle request to emit a partial beat
//   m          : packed output stream (data/keep/valid/ready)
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int PACK_RATIO = fifo_pkg::PACK_RATIO,
    parameter int TIMEOUT    = 64,
    parameter int IDLE_W     = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    fifo_rd_packer_if.master      m
);
    localparam int CW = $clog2(PACK_RATIO + 1);

    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH*PACK_RATIO-1:0]      packed_beat;
    logic [CW-1:0]                         cnt;
    logic [CW-1:0]                         wr_lane;
    logic [IDLE_W-1:0]                     idle;
    logic                                  flush_pend;
    logic                                  full;
    logic                                  out_free;
    logic                                  timeout_hit;
    logic                                  xfer;
    logic                                  pop;

    assign full        = cnt == CW'(PACK_RATIO);
    assign out_free    = !m.valid || m.ready;
    assign timeout_hit = (TIMEOUT != 0) && (idle == IDLE_W'(TIMEOUT));
    assign xfer        = out_free && (full || (cnt != '0 && (flush_pend || timeout_hit)));
    // Popping while full is allowed when the beat leaves this cycle: the new word lands in lane 0.
    assign pop         = !rst && !fifo_empty && (!full || xfer);
    assign fifo_rd_en  = pop;
    assign wr_lane     = xfer ? '0 : cnt;

    // Lanes above cnt may hold stale words from an earlier beat, so they are zeroed here.
    for (genvar i = 0; i < PACK_RATIO; i++) begin : g_lane
        assign packed_beat[i*DATA_WIDTH +: DATA_WIDTH] = (CW'(i) < cnt) ? acc[i] : '0;
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            idle       <= '0;
            flush_pend <= 1'b0;
            m.data     <= '0;
            m.keep     <= '0;
            m.valid    <= 1'b0;
        end else begin
            for (int i = 0; i < PACK_RATIO; i++)
                if (pop && wr_lane == CW'(i))
                    acc[i] <= fifo_dout;
            cnt <= xfer ? (pop ? CW'(1) : '0) : (pop ? cnt + CW'(1) : cnt);
            if (xfer) begin
                m.data  <= packed_beat;
                m.keep  <= PACK_RATIO'(keep_mask(32'(cnt)));
                m.valid <= 1'b1;
            end else if (m.ready) begin
                m.valid <= 1'b0;
            end
            // A flush with nothing held and nothing arriving is dropped, so no empty beat exists.
            flush_pend <= xfer ? 1'b0 : ((flush && (cnt != '0 || pop)) ? 1'b1 : flush_pend);
            idle <= (pop || xfer) ? '0
                  : (cnt != '0 && !full && idle != IDLE_W'(TIMEOUT)) ? idle + IDLE_W'(1) : idle;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: randomized and directed checks of fifo_rd_packer against a queue-based model
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int DW = 32;
    localparam int R  = 4;
    localparam int T  = 5;
    localparam int BW = DW * R;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          flush;

    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(R)) m();

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(R), .TIMEOUT(T), .IDLE_W(8)) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m          (m)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_pop = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] accq[$];
    logic          mv;
    logic [BW-1:0] md;
    logic [R-1:0]  mk;
    logic          fp;
    int            idle;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = fq.size() == 0;
        fifo_dout  = fq.size() != 0 ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        upd_fifo();
    endtask

    task automatic reset_model();
        accq.delete();
        mv = 1'b0;
        md = '0;
        mk = '0;
        fp = 1'b0;
        idle = 0;
    endtask

    // One clock: drive inputs, predict the pop, advance the model, compare the registered outputs.
    task automatic cycle(input logic fl, input logic rdy);
        logic xf, pop, free;
        int n;
        flush   = fl;
        m.ready = rdy;
        #1;
        n    = accq.size();
        free = !mv || rdy;
        xf   = free && (n == R || (n > 0 && (fp || idle == T)));
        pop  = fq.size() > 0 && (n < R || xf);
        check("rd_en", fifo_rd_en, pop);
        if (xf) begin
            md = '0;
            foreach (accq[i]) md[i*DW +: DW] = accq[i];
            mk = R'((1 << n) - 1);
            mv = 1'b1;
            accq.delete();
        end else if (rdy) begin
            mv = 1'b0;
        end
        fp   = xf ? 1'b0 : ((fl && (n > 0 || pop)) ? 1'b1 : fp);
        idle = (pop || xf) ? 0 : ((n > 0 && n < R && idle < T) ? idle + 1 : idle);
        if (pop) begin
            accq.push_back(fq[0]);
            n_pop++;
        end
        @(posedge rd_clk);
        #1;
        if (pop) void'(fq.pop_front());
        upd_fifo();
        check("m_valid", m.valid, mv);
        check("m_keep", m.keep, mk);
        check("m_data", m.data, md);
    endtask

    initial begin
        int base;
        flush   = 1'b0;
        m.ready = 1'b0;
        reset_model();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        repeat (2) @(posedge rd_clk);
        #1;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", m.valid, 0);
        check("rst_keep", m.keep, 0);
        check("rst_data", m.data, 0);
        rst = 1'b0;

        base = n_pop;
        repeat (12) cycle(1'b0, 1'b1);
        check("stream_pops", n_pop - base, 8);
        check("stream_beat2", m.data, {32'h8, 32'h7, 32'h6, 32'h5});

        base = n_pop;
        for (int i = 9; i <= 16; i++) push(DW'(i));
        repeat (12) cycle(1'b0, 1'b0);
        check("bp_pops", n_pop - base, 8);
        check("bp_data", m.data, {32'h4 + 32'h8, 32'h3 + 32'h8, 32'h2 + 32'h8, 32'h1 + 32'h8});
        repeat (6) cycle(1'b0, 1'b1);
        check("bp_beat2", m.data, {32'd16, 32'd15, 32'd14, 32'd13});

        push(32'hA);
        push(32'hB);
        push(32'hC);
        repeat (4) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        check("flush_keep", m.keep, 4'b0111);
        check("flush_data", m.data, {32'h0, 32'hC, 32'hB, 32'hA});
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);

        push(32'h11);
        push(32'h22);
        repeat (10) cycle(1'b0, 1'b1);
        check("to_keep", m.keep, 4'b0011);

        for (int i = 0; i < 4; i++) push(32'h100 + DW'(i));
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (8) cycle(1'b0, 1'b1);
        check("fl4_keep", m.keep, 4'hF);

        for (int i = 0; i < 6; i++) push(32'h200 + DW'(i));
        repeat (7) cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(32'h300 + DW'(i));
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", m.valid, 0);
        check("arst_keep", m.keep, 0);
        check("arst_rd_en", fifo_rd_en, 0);
        reset_model();
        @(posedge rd_clk);
        #1;
        rst = 1'b0;
        repeat (8) cycle(1'b0, 1'b1);
        check("post_rst", m.data, {32'h303, 32'h302, 32'h301, 32'h300});

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) push($urandom);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (30) cycle(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side drain stage placed directly downstream of the team's async FIFO, in the read clock domain. It pops 32-bit words from the FIFO read port and packs PACK_RATIO consecutive words into one wide output beat. Output uses a valid/ready handshake. Partial beats are emitted, with a lane-keep mask, on an explicit flush or after an idle timeout.

Parameters:
DATA_WIDTH, 32, width of one FIFO word
PACK_RATIO, 4, FIFO words per output beat (>=2)
TIMEOUT, 64, idle cycles before a partial beat auto-flushes; 0 disables auto-flush
IDLE_W, 16, width of idle counter (must hold TIMEOUT)

Ports:
rd_clk  input  1  read-domain clock, all logic posedge
rst  input  1  asynchronous, active-high reset
fifo_dout  input  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0 (show-ahead)
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  pop strobe; FIFO advances at the rd_clk edge where fifo_rd_en=1
m_data  output  DATA_WIDTH*PACK_RATIO  packed beat; lane 0 = bits [DATA_WIDTH-1:0] = oldest word
m_keep  output  PACK_RATIO  per-lane valid mask for m_data
m_valid  output  1  beat valid
m_ready  input  1  downstream accept
flush  input  1  single-cycle request to emit any partial beat

Behaviour:
- Clock/reset: one clock, rd_clk. rst is asynchronous and active-high. Reset drives cnt=0, idle=0, flush_pend=0, acc=0. Outputs reset to m_valid=0, m_data=0, m_keep=0, fifo_rd_en=0 (fifo_rd_en is gated by rst).
- Reset mid-operation discards accumulated lanes and any unaccepted beat.
- Accumulator: PACK_RATIO lanes plus cnt (0..PACK_RATIO), the number of filled lanes.
- Output register: holds m_data, m_keep, m_valid.
- out_free = !m_valid || m_ready.
- xfer = out_free && (cnt==PACK_RATIO || (cnt>0 && (flush_pend || timeout_hit))).
- pop = fifo_rd_en = !rst && !fifo_empty && (cnt<PACK_RATIO || xfer). This is combinational and never asserted while fifo_empty=1.
- On pop: fifo_dout is written into lane (xfer ? 0 : cnt).
- cnt update: xfer && pop -> 1; xfer only -> 0; pop only -> cnt+1.
- On xfer:
  - m_data <= accumulator, with unfilled lanes zeroed.
  - m_keep <= (1<<cnt)-1.
  - m_valid <= 1; flush_pend <= 0; idle <= 0.
- m_valid clears on m_ready only when no xfer occurs that cycle.
- While m_valid && !m_ready: m_data and m_keep hold stable, m_valid stays 1.
- Latency: if the final lane is popped at edge N and out_free holds, m_valid=1 after edge N+1.
- Throughput: sustained 1 pop per cycle while m_ready=1 and the FIFO is non-empty, since xfer and the next pop share a cycle.
- Backpressure: acc full and output stalled -> fifo_rd_en=0 until the beat is accepted.
- flush: sets flush_pend when cnt>0 or pop occurs that cycle. A flush with cnt==0 and no pop is ignored; no empty beat is ever produced.
- Idle timer:
  - idle increments when 0<cnt<PACK_RATIO and no pop, saturating at TIMEOUT.
  - It clears on pop or xfer.
  - timeout_hit = (TIMEOUT!=0) && idle==TIMEOUT.
- Simultaneous flush and final-lane pop: a full beat is emitted with m_keep all-ones; flush_pend clears with that xfer.
- Lane order: words leave in FIFO order; m_keep is always a contiguous run from lane 0.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH and PACK_RATIO defaults.
  - A clog2-based constant for the cnt width.
  - A keep_mask(cnt) function returning (1<<cnt)-1.
- Single module; no sub-module. The accumulator and output register are small enough to stay inline.

Test Plan:
- Steady stream: FIFO preloaded with 0x1..0x8, m_ready=1 -> two beats, 0x00000004_00000003_00000002_00000001 then 0x8_7_6_5 ordering, m_keep=4'hF; 8 pops on 8 consecutive cycles.
- Backpressure: m_ready=0, 8 words available -> exactly 8 pops (4 in acc, 4 in output), fifo_rd_en=0 thereafter, m_data stable. Raising m_ready yields both beats back to back.
- Explicit flush: 3 words 0xA,0xB,0xC then flush pulse -> one beat, m_keep=4'b0111, lane3=0; a flush with cnt==0 produces no beat.
- Timeout: TIMEOUT=5, 2 words then FIFO empty -> beat with m_keep=4'b0011 exactly 5 idle cycles after the last pop (xfer on the cycle idle==5).
- Flush coincident with 4th pop -> single full beat, m_keep=4'hF, no extra partial beat afterwards.
- Reset: assert rst with cnt=2 and m_valid=1 unaccepted -> asynchronously m_valid=0, m_keep=0, fifo_rd_en=0. After release, the next 4 words form a clean beat.
